uart_dbus_bridge: RTL and testbench
===================================

Name: uart_dbus_bridge

Overview:
Glue stage between the host-side UART and the TI-link D-bus driver (dbus). Host-to-calculator bytes from the UART receiver are buffered in an H2C FIFO and handed one at a time to the dbus transmit handshake (i_data/i_enable/o_busy). Calculator-to-host bytes are drained from the dbus receive side (o_data/o_avail/i_read) into a C2H FIFO and presented to the UART transmitter over valid/ready. Backpressure toward the link comes from not acknowledging dbus o_avail.

Parameters:
H2C_AW, 4, log2 depth of the host-to-calc FIFO (16 entries)
C2H_AW, 4, log2 depth of the calc-to-host FIFO (16 entries)

Ports:
i_clock  in  1  system clock
i_reset  in  1  asynchronous, active-high reset
i_rx_data  in  8  byte from UART receiver
i_rx_valid  in  1  one-cycle strobe, i_rx_data valid
o_tx_data  out  8  byte to UART transmitter (C2H FIFO head)
o_tx_valid  out  1  C2H FIFO non-empty
i_tx_ready  in  1  UART transmitter accepts o_tx_data when high with o_tx_valid
o_dbus_data  out  8  to dbus i_data
o_dbus_enable  out  1  to dbus i_enable
o_dbus_read  out  1  to dbus i_read
i_dbus_data  in  8  from dbus o_data
i_dbus_busy  in  1  from dbus o_busy
i_dbus_avail  in  1  from dbus o_avail
i_dbus_receiving  in  1  from dbus o_receiving
i_dbus_reset  in  1  from dbus o_reset (timeout recovery)
i_clear_status  in  1  clears sticky flags
o_h2c_overflow  out  1  sticky: UART byte dropped, H2C full
o_tx_error  out  1  sticky: byte lost to dbus timeout/reset
o_h2c_level  out  H2C_AW+1  H2C occupancy

Behaviour:
- Reset (async, i_reset high): both FIFOs empty, all pointers 0, TX FSM IDLE, RX FSM IDLE; o_dbus_enable=0, o_dbus_read=0, o_tx_valid=0, o_h2c_overflow=0, o_tx_error=0, o_h2c_level=0, o_dbus_data=0, o_tx_data=0.
- FIFOs: synchronous write, head visible combinationally; pointers H2C_AW+1 / C2H_AW+1 bits, full when MSBs differ and rest equal; wrap naturally. Simultaneous push+pop on full/empty handled per-case below.
- H2C push: i_rx_valid && !full -> write. i_rx_valid && full -> byte dropped, o_h2c_overflow<=1. Push and pop in same cycle: level unchanged; push on full with pop same cycle is still dropped (full evaluated before pop).
- TX FSM (H2C -> dbus):
  IDLE: if H2C non-empty, register o_dbus_data<=head, o_dbus_enable<=1, -> REQ. Head not popped yet.
  REQ: hold data/enable stable. If i_dbus_busy && !i_dbus_receiving && !i_dbus_reset -> o_dbus_enable<=0, pop H2C, -> SEND. If busy with receiving or reset high: keep waiting, enable stays high (dbus starts TX once it goes idle).
  SEND: wait !i_dbus_busy -> IDLE. If i_dbus_reset seen high at any cycle in SEND: o_tx_error<=1, byte not retried; still exit on !busy.
  Minimum inter-byte gap: 1 cycle in IDLE.
- RX FSM (dbus -> C2H):
  IDLE: if i_dbus_avail && C2H not full: push i_dbus_data, o_dbus_read<=1 (exactly one cycle), -> WAIT.
  WAIT: o_dbus_read=0; stay until !i_dbus_avail (dbus clears avail ~2 cycles after read), then -> IDLE. Prevents double capture.
  C2H full: no read issued; dbus holds avail and refuses further link receives (natural backpressure), no data loss.
- C2H pop: o_tx_valid && i_tx_ready. o_tx_data = head; stable while valid and not ready.
- i_clear_status: clears both sticky flags next cycle; a set event in the same cycle wins.
- i_dbus_reset in TX IDLE/REQ or RX states: no action beyond above; bridge never resets dbus.

Test Plan:
- Push 0x55 via i_rx_valid, dbus model idle -> o_dbus_enable high with o_dbus_data=0x55 until busy&&!receiving, then enable low; H2C level 1->0; no second enable until busy falls.
- Push 0xA1, 0xB2, 0xC3 back-to-back -> three dbus transmissions in order, each separated by busy low, o_h2c_overflow=0.
- Fill H2C with 16 bytes while dbus busy, push 17th (0xEE) -> o_h2c_overflow=1, level=16, 0xEE never transmitted; i_clear_status -> flag 0.
- Model raises busy+receiving while REQ holds 0x42 -> enable stays high, no pop; after receive ends and TX busy appears, 0x42 popped and sent once.
- Dbus avail with data 0x7E -> single-cycle o_dbus_read, C2H gets 0x7E, o_tx_valid=1; with i_tx_ready=0 for 5 cycles data stable, then pops on ready.
- Assert i_dbus_reset during SEND of 0x10 -> o_tx_error=1, 0x10 not retried; next queued byte 0x11 sent normally; async i_reset mid-transfer -> all outputs 0 immediately.

Source files
------------

// File: rtl/uart_dbus_bridge.sv
// UART <-> D-bus glue stage.
// Host-to-calc bytes are queued in the H2C FIFO and offered one at a time to the
// dbus transmit handshake. Calc-to-host bytes are pulled from the dbus receive
// side into the C2H FIFO and presented to the UART transmitter over valid/ready.
// When C2H is full, o_avail is left unacknowledged, so the link is throttled
// and no data is lost.
module uart_dbus_bridge #(
    parameter int H2C_AW = 4,
    parameter int C2H_AW = 4
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_valid,
    input  logic              i_tx_ready,
    output logic [7:0]        o_dbus_data,
    output logic              o_dbus_enable,
    output logic              o_dbus_read,
    input  logic [7:0]        i_dbus_data,
    input  logic              i_dbus_busy,
    input  logic              i_dbus_avail,
    input  logic              i_dbus_receiving,
    input  logic              i_dbus_reset,
    input  logic              i_clear_status,
    output logic              o_h2c_overflow,
    output logic              o_tx_error,
    output logic [H2C_AW:0]   o_h2c_level
);
    localparam int H2C_DEPTH = 1 << H2C_AW;
    localparam int C2H_DEPTH = 1 << C2H_AW;

    typedef enum logic [1:0] {TX_IDLE, TX_REQ, TX_SEND} tx_state_t;
    typedef enum logic {RX_IDLE, RX_WAIT} rx_state_t;

    tx_state_t tx_state_reg;
    rx_state_t rx_state_reg;

    // ---------------- H2C FIFO ----------------
    logic [7:0]      h2c_mem [H2C_DEPTH];
    logic [H2C_AW:0] h2c_wr_ptr_reg;
    logic [H2C_AW:0] h2c_rd_ptr_reg;
    logic            h2c_full;
    logic            h2c_empty;
    logic            h2c_push;
    logic            h2c_pop;
    logic [7:0]      h2c_head;

    assign h2c_empty   = (h2c_wr_ptr_reg == h2c_rd_ptr_reg);
    assign h2c_full    = (h2c_wr_ptr_reg[H2C_AW] != h2c_rd_ptr_reg[H2C_AW]) &&
                         (h2c_wr_ptr_reg[H2C_AW-1:0] == h2c_rd_ptr_reg[H2C_AW-1:0]);
    // Fullness is judged before any same-cycle pop, so a byte arriving on a
    // full FIFO is dropped even if the head leaves in that cycle.
    assign h2c_push    = i_rx_valid && !h2c_full;
    assign h2c_head    = h2c_mem[h2c_rd_ptr_reg[H2C_AW-1:0]];
    assign o_h2c_level = h2c_wr_ptr_reg - h2c_rd_ptr_reg;

    // The head leaves the FIFO only once dbus has really started our transmit
    // (busy without receiving and no timeout reset in progress).
    assign h2c_pop = (tx_state_reg == TX_REQ) && i_dbus_busy &&
                     !i_dbus_receiving && !i_dbus_reset;

    // H2C storage write
    always_ff @(posedge i_clock) begin
        if (h2c_push) begin
            h2c_mem[h2c_wr_ptr_reg[H2C_AW-1:0]] <= i_rx_data;
        end
    end

    // H2C pointer update
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            h2c_wr_ptr_reg <= '0;
            h2c_rd_ptr_reg <= '0;
        end else begin
            if (h2c_push) h2c_wr_ptr_reg <= h2c_wr_ptr_reg + 1'b1;
            if (h2c_pop)  h2c_rd_ptr_reg <= h2c_rd_ptr_reg + 1'b1;
        end
    end

    // ---------------- C2H FIFO ----------------
    logic [7:0]      c2h_mem [C2H_DEPTH];
    logic [C2H_AW:0] c2h_wr_ptr_reg;
    logic [C2H_AW:0] c2h_rd_ptr_reg;
    logic            c2h_full;
    logic            c2h_empty;
    logic            c2h_push;
    logic            c2h_pop;

    assign c2h_empty = (c2h_wr_ptr_reg == c2h_rd_ptr_reg);
    assign c2h_full  = (c2h_wr_ptr_reg[C2H_AW] != c2h_rd_ptr_reg[C2H_AW]) &&
                       (c2h_wr_ptr_reg[C2H_AW-1:0] == c2h_rd_ptr_reg[C2H_AW-1:0]);
    // Capture only from RX IDLE, so a byte still flagged avail after its read
    // is never taken twice.
    assign c2h_push  = (rx_state_reg == RX_IDLE) && i_dbus_avail && !c2h_full;
    assign c2h_pop   = !c2h_empty && i_tx_ready;

    assign o_tx_valid = !c2h_empty;
    // Stale storage is masked so the UART side sees zero when nothing is queued.
    assign o_tx_data  = c2h_empty ? 8'h00 : c2h_mem[c2h_rd_ptr_reg[C2H_AW-1:0]];

    // C2H storage write
    always_ff @(posedge i_clock) begin
        if (c2h_push) begin
            c2h_mem[c2h_wr_ptr_reg[C2H_AW-1:0]] <= i_dbus_data;
        end
    end

    // C2H pointer update
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            c2h_wr_ptr_reg <= '0;
            c2h_rd_ptr_reg <= '0;
        end else begin
            if (c2h_push) c2h_wr_ptr_reg <= c2h_wr_ptr_reg + 1'b1;
            if (c2h_pop)  c2h_rd_ptr_reg <= c2h_rd_ptr_reg + 1'b1;
        end
    end

    // TX FSM: offer the H2C head to dbus and hold it until dbus takes it
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            tx_state_reg  <= TX_IDLE;
            o_dbus_enable <= 1'b0;
            o_dbus_data   <= 8'h00;
        end else begin
            case (tx_state_reg)
                TX_IDLE: begin
                    if (!h2c_empty) begin
                        o_dbus_data   <= h2c_head;
                        o_dbus_enable <= 1'b1;
                        tx_state_reg  <= TX_REQ;
                    end
                end
                TX_REQ: begin
                    // Busy caused by a link receive or a timeout reset is not our
                    // transmit; keep enable up so dbus sends once it is idle.
                    if (h2c_pop) begin
                        o_dbus_enable <= 1'b0;
                        tx_state_reg  <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    if (!i_dbus_busy) tx_state_reg <= TX_IDLE;
                end
                default: begin
                    o_dbus_enable <= 1'b0;
                    tx_state_reg  <= TX_IDLE;
                end
            endcase
        end
    end

    // RX FSM: one-cycle read acknowledge per available byte, then wait for avail to drop
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            rx_state_reg <= RX_IDLE;
            o_dbus_read  <= 1'b0;
        end else begin
            o_dbus_read <= 1'b0;
            case (rx_state_reg)
                RX_IDLE: begin
                    if (c2h_push) begin
                        o_dbus_read  <= 1'b1;
                        rx_state_reg <= RX_WAIT;
                    end
                end
                RX_WAIT: begin
                    if (!i_dbus_avail) rx_state_reg <= RX_IDLE;
                end
                default: rx_state_reg <= RX_IDLE;
            endcase
        end
    end

    // Sticky overflow flag: a drop in the same cycle as a clear keeps it set
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_h2c_overflow <= 1'b0;
        end else if (i_rx_valid && h2c_full) begin
            o_h2c_overflow <= 1'b1;
        end else if (i_clear_status) begin
            o_h2c_overflow <= 1'b0;
        end
    end

    // Sticky transmit-error flag: dbus timeout reset while our byte is on the wire
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_tx_error <= 1'b0;
        end else if ((tx_state_reg == TX_SEND) && i_dbus_reset) begin
            o_tx_error <= 1'b1;
        end else if (i_clear_status) begin
            o_tx_error <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_dbus_bridge.sv
// Testbench for uart_dbus_bridge: behavioural dbus model plus queue-based
// expectations for both directions.
module tb_uart_dbus_bridge;
    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] dbus_data_out;
    logic       dbus_enable;
    logic       dbus_read;
    logic [7:0] dbus_data_in;
    logic       dbus_busy;
    logic       dbus_avail;
    logic       dbus_receiving;
    logic       dbus_reset;
    logic       clear_status;
    logic       h2c_overflow;
    logic       tx_error;
    logic [4:0] h2c_level;

    uart_dbus_bridge #(.H2C_AW(4), .C2H_AW(4)) dut (
        .i_clock          (clk),
        .i_reset          (rst),
        .i_rx_data        (rx_data),
        .i_rx_valid       (rx_valid),
        .o_tx_data        (tx_data),
        .o_tx_valid       (tx_valid),
        .i_tx_ready       (tx_ready),
        .o_dbus_data      (dbus_data_out),
        .o_dbus_enable    (dbus_enable),
        .o_dbus_read      (dbus_read),
        .i_dbus_data      (dbus_data_in),
        .i_dbus_busy      (dbus_busy),
        .i_dbus_avail     (dbus_avail),
        .i_dbus_receiving (dbus_receiving),
        .i_dbus_reset     (dbus_reset),
        .i_clear_status   (clear_status),
        .o_h2c_overflow   (h2c_overflow),
        .o_tx_error       (tx_error),
        .o_h2c_level      (h2c_level)
    );

    // ---------------- dbus behavioural model ----------------
    bit         force_recv = 1'b0;   // link receive in progress (busy+receiving)
    int         tx_len = 3;          // cycles a transmit keeps busy high
    bit         tx_busy = 1'b0;
    int         tx_cnt = 0;
    logic [7:0] sent_q[$];           // every byte dbus started to transmit

    assign dbus_busy      = tx_busy | force_recv;
    assign dbus_receiving = force_recv;

    // dbus transmit side: latch the byte when enable is seen while idle
    always @(posedge clk) begin
        if (tx_busy) begin
            if (tx_cnt <= 1) tx_busy <= 1'b0;
            tx_cnt <= tx_cnt - 1;
        end else if (dbus_enable && !force_recv) begin
            sent_q.push_back(dbus_data_out);
            tx_busy <= 1'b1;
            tx_cnt  <= tx_len;
        end
    end

    logic [7:0] rx_src[$];           // bytes the link will deliver, in order
    int         rx_reads = 0;        // cycles on which read was seen high
    int         rx_clr = 0;
    logic       avail_r = 1'b0;
    logic [7:0] dat_r = 8'h00;
    assign dbus_avail   = avail_r;
    assign dbus_data_in = dat_r;

    // dbus receive side: avail held until two cycles after a read acknowledge
    always @(posedge clk) begin
        if (avail_r) begin
            if (dbus_read) begin
                rx_reads <= rx_reads + 1;
                rx_clr   <= 2;
            end else if (rx_clr == 1) begin
                avail_r <= 1'b0;
                rx_clr  <= 0;
            end else if (rx_clr > 1) begin
                rx_clr <= rx_clr - 1;
            end
        end else if (rx_src.size() > 0) begin
            avail_r <= 1'b1;
            dat_r   <= rx_src.pop_front();
        end
    end

    logic [7:0] got_q[$];            // bytes accepted by the UART transmitter
    // UART transmitter side monitor
    always @(posedge clk) begin
        if (!rst && tx_valid && tx_ready) got_q.push_back(tx_data);
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_status = 1'b1;
        @(negedge clk);
        clear_status = 1'b0;
    endtask

    typedef struct {
        logic [7:0] data;
        int         len;
        bit         recv_first;
        bit         rst_in_send;
        bit         exp_err;
    } vec_t;

    vec_t       vecs[4];
    logic [7:0] exp_h2c[$];
    logic [7:0] exp_c2h[$];
    int         n;
    int         base;
    int         rb;
    int         gb;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b0;
        dbus_reset = 1'b0; clear_status = 1'b0;

        vecs[0] = '{8'h55, 3, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'h42, 4, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h10, 6, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{8'h11, 3, 1'b0, 1'b0, 1'b0};

        // ---- reset state ----
        repeat (2) @(negedge clk);
        chk("rst_enable", dbus_enable, 0);
        chk("rst_read", dbus_read, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_overflow", h2c_overflow, 0);
        chk("rst_tx_error", tx_error, 0);
        chk("rst_level", h2c_level, 0);
        chk("rst_dbus_data", dbus_data_out, 0);
        chk("rst_tx_data", tx_data, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // ---- table-driven single-byte transfers ----
        for (int vi = 0; vi < 4; vi++) begin
            vec_t v;
            v = vecs[vi];
            tx_len = v.len;
            base = sent_q.size();
            if (v.recv_first) force_recv = 1'b1;
            push_byte(v.data);
            n = 0;
            while (!dbus_enable && n < 50) begin @(negedge clk); n++; end
            chk("vec_enable", dbus_enable, 1);
            chk("vec_req_data", dbus_data_out, v.data);
            chk("vec_req_level", h2c_level, 1);
            if (v.recv_first) begin
                repeat (6) begin
                    @(negedge clk);
                    chk("vec_hold_enable", dbus_enable, 1);
                    chk("vec_hold_level", h2c_level, 1);
                end
                chk("vec_hold_nosend", sent_q.size() - base, 0);
                force_recv = 1'b0;
            end
            n = 0;
            while (sent_q.size() == base && n < 50) begin @(negedge clk); n++; end
            n = 0;
            while (dbus_enable && n < 10) begin @(negedge clk); n++; end
            chk("vec_enable_low", dbus_enable, 0);
            if (v.rst_in_send) begin
                dbus_reset = 1'b1;
                @(negedge clk);
                dbus_reset = 1'b0;
            end
            n = 0;
            while (dbus_busy && n < 50) begin
                chk("vec_no_reenable", dbus_enable, 0);
                @(negedge clk); n++;
            end
            repeat (3) @(negedge clk);
            chk("vec_send_count", sent_q.size() - base, 1);
            if (sent_q.size() > base) chk("vec_sent_byte", sent_q[base], v.data);
            chk("vec_level_end", h2c_level, 0);
            chk("vec_idle_enable", dbus_enable, 0);
            chk("vec_tx_error", tx_error, v.exp_err);
            pulse_clear();
            @(negedge clk);
            chk("vec_err_cleared", tx_error, 0);
        end

        // ---- back-to-back A1 B2 C3 ----
        tx_len = 3;
        base = sent_q.size();
        push_byte(8'hA1); push_byte(8'hB2); push_byte(8'hC3);
        n = 0;
        while ((sent_q.size() < base + 3 || dbus_busy) && n < 200) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        chk("b2b_count", sent_q.size() - base, 3);
        if (sent_q.size() >= base + 3) begin
            chk("b2b_0", sent_q[base], 8'hA1);
            chk("b2b_1", sent_q[base+1], 8'hB2);
            chk("b2b_2", sent_q[base+2], 8'hC3);
        end
        chk("b2b_overflow", h2c_overflow, 0);
        chk("b2b_level", h2c_level, 0);

        // ---- H2C overflow ----
        force_recv = 1'b1;
        base = sent_q.size();
        for (int i = 0; i < 16; i++) push_byte(8'h80 + 8'(i));
        chk("ovf_not_yet", h2c_overflow, 0);
        push_byte(8'hEE);
        chk("ovf_flag", h2c_overflow, 1);
        chk("ovf_level", h2c_level, 16);
        chk("ovf_req_head", dbus_data_out, 8'h80);
        clear_status = 1'b1;                 // clear and a new drop in the same cycle
        push_byte(8'hEF);
        clear_status = 1'b0;
        chk("ovf_set_wins", h2c_overflow, 1);
        pulse_clear();
        chk("ovf_cleared", h2c_overflow, 0);
        tx_len = 2;
        force_recv = 1'b0;
        n = 0;
        while ((sent_q.size() < base + 16 || dbus_busy) && n < 600) begin @(negedge clk); n++; end
        repeat (5) @(negedge clk);
        chk("ovf_sent_count", sent_q.size() - base, 16);
        for (int i = 0; i < 16; i++) begin
            if (sent_q.size() > base + i) chk("ovf_sent_byte", sent_q[base+i], 8'h80 + 8'(i));
        end
        chk("ovf_drain_level", h2c_level, 0);

        // ---- C2H single byte with stalled UART ----
        tx_ready = 1'b0;
        rb = rx_reads;
        gb = got_q.size();
        rx_src.push_back(8'h7E);
        n = 0;
        while (!tx_valid && n < 20) begin @(negedge clk); n++; end
        chk("c2h_valid", tx_valid, 1);
        chk("c2h_data", tx_data, 8'h7E);
        repeat (5) begin
            @(negedge clk);
            chk("c2h_stable_valid", tx_valid, 1);
            chk("c2h_stable_data", tx_data, 8'h7E);
        end
        chk("c2h_one_read", rx_reads - rb, 1);
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        chk("c2h_popped", got_q.size() - gb, 1);
        if (got_q.size() > gb) chk("c2h_popped_byte", got_q[gb], 8'h7E);
        chk("c2h_empty", tx_valid, 0);

        // ---- C2H full backpressure ----
        rb = rx_reads;
        gb = got_q.size();
        for (int i = 0; i < 20; i++) rx_src.push_back(8'h20 + 8'(i));
        repeat (150) @(negedge clk);
        chk("full_reads", rx_reads - rb, 16);
        chk("full_avail_held", dbus_avail, 1);
        chk("full_read_low", dbus_read, 0);
        tx_ready = 1'b1;
        n = 0;
        while (got_q.size() < gb + 20 && n < 400) begin @(negedge clk); n++; end
        tx_ready = 1'b0;
        chk("full_got_count", got_q.size() - gb, 20);
        for (int i = 0; i < 20; i++) begin
            if (got_q.size() > gb + i) chk("full_got_byte", got_q[gb+i], 8'h20 + 8'(i));
        end
        chk("full_reads_total", rx_reads - rb, 20);

        // ---- randomized traffic in both directions ----
        for (int r = 0; r < 6; r++) begin
            int nb;
            int nc;
            exp_h2c.delete();
            exp_c2h.delete();
            base = sent_q.size();
            gb = got_q.size();
            tx_len = $urandom_range(2, 5);
            nc = $urandom_range(1, 10);
            for (int i = 0; i < nc; i++) begin
                logic [7:0] b;
                b = 8'($urandom);
                exp_c2h.push_back(b);
                rx_src.push_back(b);
            end
            nb = $urandom_range(1, 12);
            for (int i = 0; i < nb; i++) begin
                logic [7:0] b;
                b = 8'($urandom);
                exp_h2c.push_back(b);
                tx_ready = 1'($urandom_range(0, 1));
                push_byte(b);
                repeat ($urandom_range(0, 2)) begin
                    tx_ready = 1'($urandom_range(0, 1));
                    @(negedge clk);
                end
            end
            n = 0;
            while ((sent_q.size() < base + nb || got_q.size() < gb + nc || dbus_busy) && n < 1000) begin
                tx_ready = 1'($urandom_range(0, 1));
                @(negedge clk); n++;
            end
            tx_ready = 1'b0;
            repeat (4) @(negedge clk);
            chk("rnd_h2c_count", sent_q.size() - base, nb);
            chk("rnd_c2h_count", got_q.size() - gb, nc);
            for (int i = 0; i < nb; i++)
                if (sent_q.size() > base + i) chk("rnd_h2c_byte", sent_q[base+i], exp_h2c[i]);
            for (int i = 0; i < nc; i++)
                if (got_q.size() > gb + i) chk("rnd_c2h_byte", got_q[gb+i], exp_c2h[i]);
            chk("rnd_overflow", h2c_overflow, 0);
            chk("rnd_tx_error", tx_error, 0);
        end

        // ---- asynchronous reset in the middle of traffic ----
        tx_ready = 1'b0;
        force_recv = 1'b1;
        rx_src.push_back(8'h9C);
        push_byte(8'h5A);
        repeat (8) @(negedge clk);
        chk("arst_pre_enable", dbus_enable, 1);
        chk("arst_pre_valid", tx_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_enable", dbus_enable, 0);
        chk("arst_read", dbus_read, 0);
        chk("arst_tx_valid", tx_valid, 0);
        chk("arst_tx_data", tx_data, 0);
        chk("arst_dbus_data", dbus_data_out, 0);
        chk("arst_level", h2c_level, 0);
        chk("arst_overflow", h2c_overflow, 0);
        chk("arst_tx_error", tx_error, 0);
        @(negedge clk);
        force_recv = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
